// File: rtl/psg_reg_file_if_pkg.sv
// Shared types and sizes for the SN76489-compatible PSG write front end.
// Bus FSM states, register-type tags and register-file geometry.
package psg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        SETTLE,
        APPLY
    } bus_state_e;

    typedef enum logic {
        TONE  = 1'b0,
        ATTEN = 1'b1
    } reg_type_e;

    localparam int NUM_CH   = 4;
    localparam int NUM_TONE = 3;
    localparam int TONE_W   = 10;
    localparam int ATTEN_W  = 4;
    localparam int NOISE_W  = 3;

endpackage

// File: rtl/psg_reg_file_if_if.sv
// Z80 bus snoop interface carrying the PSG port write signals.
// master drives the bus, slave snoops it.
interface psg_reg_file_if_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] addr;
    logic              MREQ_N;
    logic              WR_N;
    logic [7:0]        data;

    modport master (output addr, MREQ_N, WR_N, data);
    modport slave  (input  addr, MREQ_N, WR_N, data);
endinterface

// File: rtl/psg_reg_file_if_bus_capture.sv
// Write decode, capture/settle FSM and byte register for the PSG port.
// PSG_GG_STEREO_EN adds a second matched address and a target flag.
module psg_bus_capture
    import psg_pkg::*;
#(
    parameter int                 ADDR_W        = 16,
    parameter int                 MATCH_W       = 8,
    parameter logic [MATCH_W-1:0] PSG_ADDR      = 8'h7F,
`ifdef PSG_GG_STEREO_EN
    parameter logic [MATCH_W-1:0] STEREO_ADDR   = 8'h06,
`endif
    parameter int                 SETTLE_CYCLES = 10
) (
    input  logic               clk,
    input  logic               reset_N,
    psg_reg_file_if_if.slave   bus,
    output logic [7:0]         byte_o,
`ifdef PSG_GG_STEREO_EN
    output logic               stereo_o,
`endif
    output logic               apply_o
);

    localparam logic [4:0] LAST = 5'(SETTLE_CYCLES - 1);

    bus_state_e state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [7:0] byte_q, byte_d;
    logic       act_psg, act;
    logic       unused_addr;

    assign unused_addr = ^bus.addr[ADDR_W-1:MATCH_W];
    assign act_psg = (bus.addr[MATCH_W-1:0] == PSG_ADDR)
                   && !bus.MREQ_N && !bus.WR_N;

`ifdef PSG_GG_STEREO_EN
    logic act_st, st_q, st_d;
    assign act_st = (bus.addr[MATCH_W-1:0] == STEREO_ADDR)
                  && !bus.MREQ_N && !bus.WR_N;
    assign act    = act_psg || act_st;
    assign stereo_o = st_q;
`else
    assign act = act_psg;
`endif

    // Next state, settle counting and last-value-wins byte capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
`ifdef PSG_GG_STEREO_EN
        st_d    = st_q;
        if (act && state_q != APPLY) st_d = !act_psg;
`endif
        if (act && state_q != APPLY) byte_d = bus.data;
        unique case (state_q)
            IDLE: begin
                if (act) state_d = CAPTURE;
            end
            CAPTURE: begin
                if (!act) begin
                    cnt_d   = '0;
                    state_d = (LAST == 5'd0) ? APPLY : SETTLE;
                end
            end
            SETTLE: begin
                if (act) begin
                    cnt_d   = '0;
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_d == LAST) begin
                        cnt_d   = '0;
                        state_d = APPLY;
                    end
                end
            end
            APPLY: begin
                state_d = act ? CAPTURE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter and byte registers
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            byte_q  <= '0;
`ifdef PSG_GG_STEREO_EN
            st_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
`ifdef PSG_GG_STEREO_EN
            st_q    <= st_d;
`endif
        end
    end

    assign byte_o  = byte_q;
    assign apply_o = (state_q == APPLY);

endmodule

// File: rtl/psg_reg_file_if.sv
// SN76489 write front end: latch/data decode into the full register file.
// Optional Game Gear stereo register behind PSG_GG_STEREO_EN.
module psg_reg_file_if
    import psg_pkg::*;
#(
    parameter int                 ADDR_W        = 16,
    parameter int                 MATCH_W       = 8,
    parameter logic [MATCH_W-1:0] PSG_ADDR      = 8'h7F,
    parameter int                 SETTLE_CYCLES = 10,
`ifdef PSG_GG_STEREO_EN
    parameter logic [MATCH_W-1:0] STEREO_ADDR   = 8'h06,
`endif
    parameter logic [3:0]         ATTEN_RESET   = 4'hF
) (
    input  logic                clk,
    input  logic                reset_N,
    psg_reg_file_if_if.slave    bus,
    output logic [29:0]         tone_period,
    output logic [2:0]          tone_update,
    output logic [15:0]         atten,
    output logic [3:0]          atten_update,
    output logic [2:0]          noise_ctrl,
    output logic                noise_update,
    output logic [1:0]          latched_ch,
`ifdef PSG_GG_STEREO_EN
    output logic [7:0]          stereo,
    output logic                stereo_update,
`endif
    output logic                latched_type
);

    logic [7:0] b;
    logic       apply;

    logic [NUM_TONE-1:0][TONE_W-1:0] tone_q, tone_d;
    logic [NUM_CH-1:0][ATTEN_W-1:0]  atten_q, atten_d;
    logic [NOISE_W-1:0]              noise_q, noise_d;
    logic [1:0]                      lch_q, lch_d, ch;
    reg_type_e                       ltype_q, ltype_d, typ;
    logic [NUM_TONE-1:0]             tupd_q, tupd_d;
    logic [NUM_CH-1:0]               aupd_q, aupd_d;
    logic                            nupd_q, nupd_d;
    logic                            is_st;

    psg_bus_capture #(
        .ADDR_W        (ADDR_W),
        .MATCH_W       (MATCH_W),
        .PSG_ADDR      (PSG_ADDR),
`ifdef PSG_GG_STEREO_EN
        .STEREO_ADDR   (STEREO_ADDR),
`endif
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_cap (
        .clk      (clk),
        .reset_N  (reset_N),
        .bus      (bus),
        .byte_o   (b),
`ifdef PSG_GG_STEREO_EN
        .stereo_o (is_st),
`endif
        .apply_o  (apply)
    );

`ifdef PSG_GG_STEREO_EN
    logic [7:0] st_q, st_d;
    logic       supd_q, supd_d;
`else
    assign is_st = 1'b0;
`endif

    // Latch/data decode; exactly one strobe per applied byte
    always_comb begin
        tone_d  = tone_q;
        atten_d = atten_q;
        noise_d = noise_q;
        lch_d   = lch_q;
        ltype_d = ltype_q;
        tupd_d  = '0;
        aupd_d  = '0;
        nupd_d  = 1'b0;
        ch      = b[7] ? b[6:5] : lch_q;
        typ     = b[7] ? reg_type_e'(b[4]) : ltype_q;
`ifdef PSG_GG_STEREO_EN
        st_d    = st_q;
        supd_d  = 1'b0;
        if (apply && is_st) begin
            st_d   = b;
            supd_d = 1'b1;
        end
`endif
        if (apply && !is_st) begin
            lch_d   = ch;
            ltype_d = typ;
            if (typ == ATTEN) begin
                atten_d[ch] = b[3:0];
                aupd_d[ch]  = 1'b1;
            end else if (ch == 2'd3) begin
                noise_d = b[2:0];
                nupd_d  = 1'b1;
            end else begin
                if (b[7]) tone_d[ch][3:0] = b[3:0];
                else      tone_d[ch][9:4] = b[5:0];
                tupd_d[ch] = 1'b1;
            end
        end
    end

    // Register file, latch state and strobes
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            tone_q  <= '0;
            atten_q <= {NUM_CH{ATTEN_RESET}};
            noise_q <= '0;
            lch_q   <= '0;
            ltype_q <= TONE;
            tupd_q  <= '0;
            aupd_q  <= '0;
            nupd_q  <= 1'b0;
`ifdef PSG_GG_STEREO_EN
            st_q    <= 8'hFF;
            supd_q  <= 1'b0;
`endif
        end else begin
            tone_q  <= tone_d;
            atten_q <= atten_d;
            noise_q <= noise_d;
            lch_q   <= lch_d;
            ltype_q <= ltype_d;
            tupd_q  <= tupd_d;
            aupd_q  <= aupd_d;
            nupd_q  <= nupd_d;
`ifdef PSG_GG_STEREO_EN
            st_q    <= st_d;
            supd_q  <= supd_d;
`endif
        end
    end

    assign tone_period  = tone_q;
    assign tone_update  = tupd_q;
    assign atten        = atten_q;
    assign atten_update = aupd_q;
    assign noise_ctrl   = noise_q;
    assign noise_update = nupd_q;
    assign latched_ch   = lch_q;
    assign latched_type = ltype_q;
`ifdef PSG_GG_STEREO_EN
    assign stereo        = st_q;
    assign stereo_update = supd_q;
`endif

endmodule

// File: tb/tb_psg_reg_file_if.sv
// Randomised bench for psg_reg_file_if against a register-level model.
// Build with PSG_GG_STEREO_EN to also cover the stereo register.
module tb_psg_reg_file_if;

    localparam int N = 10;

    logic clk = 1'b0;
    logic reset_N = 1'b0;

    psg_reg_file_if_if #(.ADDR_W(16)) bus ();

    logic [29:0] tone_period;
    logic [2:0]  tone_update;
    logic [15:0] atten;
    logic [3:0]  atten_update;
    logic [2:0]  noise_ctrl;
    logic        noise_update;
    logic [1:0]  latched_ch;
    logic        latched_type;
`ifdef PSG_GG_STEREO_EN
    logic [7:0]  stereo;
    logic        stereo_update;
`endif

    psg_reg_file_if #(
        .ADDR_W        (16),
        .MATCH_W       (8),
        .PSG_ADDR      (8'h7F),
        .SETTLE_CYCLES (N),
`ifdef PSG_GG_STEREO_EN
        .STEREO_ADDR   (8'h06),
`endif
        .ATTEN_RESET   (4'hF)
    ) dut (
        .clk          (clk),
        .reset_N      (reset_N),
        .bus          (bus),
        .tone_period  (tone_period),
        .tone_update  (tone_update),
        .atten        (atten),
        .atten_update (atten_update),
        .noise_ctrl   (noise_ctrl),
        .noise_update (noise_update),
        .latched_ch   (latched_ch),
`ifdef PSG_GG_STEREO_EN
        .stereo        (stereo),
        .stereo_update (stereo_update),
`endif
        .latched_type (latched_type)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int m_tone [3];
    int m_atten[4];
    int m_noise, m_ch, m_type;
    int m_stereo;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) m_tone[i] = 0;
        for (int i = 0; i < 4; i++) m_atten[i] = 15;
        m_noise = 0; m_ch = 0; m_type = 0; m_stereo = 255;
    endfunction

    // Returns expected strobes {tone[2:0], atten[3:0], noise}
    function automatic logic [7:0] model_write(int b);
        if (b >= 128) begin
            m_ch   = (b >> 5) & 3;
            m_type = (b >> 4) & 1;
        end
        if (m_type == 1) begin
            m_atten[m_ch] = b & 15;
            return 8'(1 << (1 + m_ch));
        end
        if (m_ch == 3) begin
            m_noise = b & 7;
            return 8'd1;
        end
        if (b >= 128) m_tone[m_ch] = (m_tone[m_ch] & 'h3F0) | (b & 15);
        else          m_tone[m_ch] = (m_tone[m_ch] & 15) | ((b & 63) << 4);
        return 8'(1 << (5 + m_ch));
    endfunction

    function automatic logic [7:0] strobes();
        return {tone_update, atten_update, noise_update};
    endfunction

    task automatic check_regs(string tag);
        chk({tag, " tone"}, 64'(tone_period),
            64'({10'(m_tone[2]), 10'(m_tone[1]), 10'(m_tone[0])}));
        chk({tag, " atten"}, 64'(atten),
            64'({4'(m_atten[3]), 4'(m_atten[2]), 4'(m_atten[1]), 4'(m_atten[0])}));
        chk({tag, " noise"}, 64'(noise_ctrl), 64'(m_noise));
        chk({tag, " lch"}, 64'(latched_ch), 64'(m_ch));
        chk({tag, " ltype"}, 64'(latched_type), 64'(m_type));
`ifdef PSG_GG_STEREO_EN
        chk({tag, " stereo"}, 64'(stereo), 64'(m_stereo));
`endif
    endtask

    task automatic bus_idle();
        bus.addr   = 16'($urandom);
        bus.MREQ_N = 1'b1;
        bus.WR_N   = 1'b1;
        bus.data   = 8'($urandom);
    endtask

    task automatic drive(logic [7:0] a, logic [7:0] d, logic mq, logic wr, int hold);
        @(posedge clk); #1;
        bus.addr   = {8'($urandom), a};
        bus.data   = d;
        bus.MREQ_N = mq;
        bus.WR_N   = wr;
        repeat (hold) @(posedge clk);
        #1;
        bus_idle();
    endtask

    task automatic idle_check(string tag, int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); @(negedge clk);
            chk({tag, " quiet"}, 64'(strobes()), 64'd0);
        end
    endtask

    // Strobe must appear exactly N+1 cycles after the write ends
    task automatic settle_expect(string tag, logic [7:0] exp, logic exp_st);
        for (int i = 1; i <= N + 2; i++) begin
            @(posedge clk); @(negedge clk);
            chk($sformatf("%s strobe@%0d", tag, i), 64'(strobes()),
                64'((i == N + 1) ? exp : 8'd0));
`ifdef PSG_GG_STEREO_EN
            chk($sformatf("%s st_upd@%0d", tag, i), 64'(stereo_update),
                64'((i == N + 1) ? exp_st : 1'b0));
`endif
            if (i == N + 1) check_regs(tag);
        end
        if (exp_st) begin end
    endtask

    task automatic psg_wr(string tag, logic [7:0] a, logic [7:0] d,
                          logic mq, logic wr, int hold);
        logic [7:0] exp;
        logic       est;
        exp = 8'd0;
        est = 1'b0;
        drive(a, d, mq, wr, hold);
        if (!mq && !wr && a == 8'h7F) exp = model_write(int'(d));
`ifdef PSG_GG_STEREO_EN
        if (!mq && !wr && a == 8'h06) begin
            m_stereo = int'(d);
            est = 1'b1;
        end
`endif
        settle_expect(tag, exp, est);
    endtask

    initial begin
        model_reset();
        bus_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_regs("reset");
        chk("reset strobes", 64'(strobes()), 64'd0);
        reset_N = 1'b1;

        psg_wr("w8E", 8'h7F, 8'h8E, 1'b0, 1'b0, 3);
        psg_wr("w0F", 8'h7F, 8'h0F, 1'b0, 1'b0, 3);
        chk("tone0", 64'(tone_period[9:0]), 64'h0FE);

        psg_wr("wBF", 8'h7F, 8'hBF, 1'b0, 1'b0, 2);
        psg_wr("w03", 8'h7F, 8'h03, 1'b0, 1'b0, 2);
        psg_wr("wE5", 8'h7F, 8'hE5, 1'b0, 1'b0, 1);
        psg_wr("w06", 8'h7F, 8'h06, 1'b0, 1'b0, 2);

        drive(8'h7F, 8'hC3, 1'b0, 1'b0, 2);
        idle_check("reassert", 5);
        psg_wr("w9A", 8'h7F, 8'h9A, 1'b0, 1'b0, 2);
        chk("atten0 A", 64'(atten[3:0]), 64'hA);

        psg_wr("bad addr", 8'h7E, 8'h8A, 1'b0, 1'b0, 2);
        psg_wr("wr high", 8'h7F, 8'h8A, 1'b0, 1'b1, 2);
        psg_wr("stereo", 8'h06, 8'h3C, 1'b0, 1'b0, 2);

        drive(8'h7F, 8'h85, 1'b0, 1'b0, 2);
        idle_check("pre-reset", 4);
        #2 reset_N = 1'b0;
        model_reset();
        #2 check_regs("midreset");
        chk("midreset strobes", 64'(strobes()), 64'd0);
        @(negedge clk);
        reset_N = 1'b1;
        idle_check("post-reset", N + 5);
        check_regs("post-reset");

        for (int k = 0; k < 40; k++) begin
            int kind;
            logic [7:0] a;
            logic mq, wr;
            kind = int'($urandom_range(0, 9));
            a  = (kind == 0) ? 8'h7E : (kind == 3) ? 8'h06 : 8'h7F;
            mq = (kind == 2);
            wr = (kind == 1);
            psg_wr($sformatf("rnd%0d", k), a, 8'($urandom_range(0, 255)),
                   mq, wr, int'($urandom_range(1, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
